sync_fifo_128: RTL and testbench
================================

// Module: sync_fifo_128
// PURPOSE
//  Single-clock synchronous FIFO buffering 128-bit words between a producer and a consumer.
//  Provides full/empty and programmable almost-full/almost-empty status flags.
//  All outputs are registered, so the block drops into a datapath without extra timing.
// PARAMETERS
//  DATA_W      128   word width in bits
//  DEPTH       16    number of entries; must be a power of two and >= 4
//  ALM_FULL    12    o_alm_full asserts when count >= ALM_FULL
//  ALM_EMPTY   4     o_alm_empty asserts when count <= ALM_EMPTY
// PORTS
//  clk          in   1       clock; all logic updates on the rising edge
//  reset        in   1       synchronous, active-low reset
//  i_wren       in   1       write request; i_wrdata is pushed when accepted
//  i_rden       in   1       read request; head word is popped when accepted
//  i_wrdata     in   DATA_W  write data
//  o_full       out  1       count == DEPTH
//  o_empty      out  1       count == 0
//  o_alm_full   out  1       count >= ALM_FULL
//  o_alm_empty  out  1       count <= ALM_EMPTY
//  o_rddata     out  DATA_W  read data, registered
// BEHAVIOUR
//  - Reset, when reset==0 at a clk edge:
//    - wr_ptr, rd_ptr and count cleared to 0.
//    - o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0, o_rddata=0.
//    - Memory contents are not cleared.
//    - A reset mid-traffic discards all stored data.
//  - Write acceptance: wr_acc = i_wren & (~o_full | rd_acc).
//    - Writing while full is accepted only together with a valid read.
//  - Read acceptance: rd_acc = i_rden & ~o_empty.
//    - Reading while empty is ignored; o_rddata holds its value.
//  - Read latency is 1 cycle.
//    - If rd_acc at edge N, o_rddata shows mem[rd_ptr] after edge N.
//    - With no read, o_rddata holds its last value.
//  - Write path: mem[wr_ptr] <= i_wrdata on wr_acc.
//  - Pointers are log2(DEPTH) bits, wrap naturally from DEPTH-1 to 0, and advance by 1 on each acceptance.
//  - count is log2(DEPTH)+1 bits:
//    - +1 on write only, -1 on read only.
//    - Unchanged on simultaneous accepted read+write.
//  - Simultaneous read+write when empty: only the write is accepted.
//    - count becomes 1; o_rddata is unchanged.
//  - Simultaneous read+write when full: both accepted; count stays DEPTH.
//    - The read returns the old head; the write lands in the freed slot.
//  - All four flags are registered, computed from next-count, and valid in the same cycle as the new count.
//  - No write-to-read bypass: a word written at edge N is readable from edge N+1 on.
// CONFIGURATION
//  FIFO_ERR_FLAGS_EN defined:
//    - Adds output ports o_overflow and o_underflow (1 bit each).
//    - o_overflow: one-cycle registered pulse when i_wren & ~wr_acc.
//    - o_underflow: one-cycle registered pulse when i_rden & o_empty.
//    - Both reset to 0.
//  FIFO_ERR_FLAGS_EN undefined: these ports and their logic do not exist; rejected requests are silently dropped.
// STRUCTURE
//  - Package fifo_pkg holds:
//    - constants DATA_W and DEPTH, and AW = $clog2(DEPTH);
//    - typedefs word_t (logic [DATA_W-1:0]), ptr_t (logic [AW-1:0]), cnt_t (logic [AW:0]).
//  - Sub-module fifo_mem: simple dual-port RAM.
//    - One synchronous write port and one synchronous registered read port.
//    - Read enable is rd_acc.
//  - Top level holds pointers, count, flag registers and accept logic.
// TESTING
//  - Reset: hold reset=0 for 2 cycles, then release.
//    -> o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0, o_rddata=0.
//  - Fill: write 0x1..0x10 on 16 consecutive cycles.
//    -> o_alm_empty drops after the 5th write.
//    -> o_alm_full rises after the 12th write.
//    -> o_full rises after the 16th write.
//    -> a 17th write is ignored, and pulses o_overflow when FIFO_ERR_FLAGS_EN is defined.
//  - Drain: 16 reads.
//    -> o_rddata = 0x1..0x10 in order, each one cycle after its read.
//    -> o_empty=1 after the last read; a 17th read leaves o_rddata=0x10.
//  - Simultaneous read+write at full: 16 entries stored, wren=rden=1, i_wrdata=0xAA.
//    -> o_full stays 1; o_rddata returns the oldest word.
//    -> 0xAA emerges as the 16th subsequent read.
//  - Simultaneous read+write at empty: wren=rden=1, i_wrdata=0x55.
//    -> count=1, o_empty=0, o_rddata unchanged; the next read returns 0x55.
//  - Wrap and mid-traffic reset: run 40 random push/pop cycles against a queue model, then assert reset for 1 cycle.
//    -> data order matches the model throughout.
//    -> after reset all flags are at reset values and count=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and types for the 128-bit synchronous FIFO.
// Word width, depth and the pointer/count widths derived from them.
package fifo_pkg;

    localparam int DATA_W = 128;
    localparam int DEPTH  = 16;
    localparam int AW     = $clog2(DEPTH);

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [AW-1:0]     ptr_t;
    typedef logic [AW:0]       cnt_t;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: synchronous write, registered synchronous read.
// Only the read register is reset; the array itself is left untouched.
module fifo_mem
    import fifo_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  wr_en,
    input  ptr_t  wr_addr,
    input  word_t wr_data,
    input  logic  rd_en,
    input  ptr_t  rd_addr,
    output word_t rd_data
);

    word_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Same-address read+write returns the old word (no bypass).
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_128.sv
// Single-clock 128-bit FIFO with registered full/empty/almost flags.
// Define FIFO_ERR_FLAGS_EN to add o_overflow/o_underflow pulse outputs.
module sync_fifo_128
    import fifo_pkg::*;
#(
    parameter int ALM_FULL  = 12,
    parameter int ALM_EMPTY = 4
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  i_wren,
    input  logic  i_rden,
    input  word_t i_wrdata,
    output logic  o_full,
    output logic  o_empty,
    output logic  o_alm_full,
    output logic  o_alm_empty,
`ifdef FIFO_ERR_FLAGS_EN
    output logic  o_overflow,
    output logic  o_underflow,
`endif
    output word_t o_rddata
);

    ptr_t wr_ptr_q;
    ptr_t rd_ptr_q;
    cnt_t count_q;
    cnt_t count_nxt;
    logic wr_acc;
    logic rd_acc;

    assign rd_acc = i_rden & ~o_empty;
    assign wr_acc = i_wren & (~o_full | rd_acc);

    always_comb begin
        count_nxt = count_q + cnt_t'(wr_acc) - cnt_t'(rd_acc);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            o_full      <= 1'b0;
            o_empty     <= 1'b1;
            o_alm_full  <= 1'b0;
            o_alm_empty <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + ptr_t'(1);
            end
            if (rd_acc) begin
                rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            end
            count_q     <= count_nxt;
            // Flags track next-count so they line up with count_q.
            o_full      <= (count_nxt == cnt_t'(DEPTH));
            o_empty     <= (count_nxt == '0);
            o_alm_full  <= (count_nxt >= cnt_t'(ALM_FULL));
            o_alm_empty <= (count_nxt <= cnt_t'(ALM_EMPTY));
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            o_overflow  <= i_wren & ~wr_acc;
            o_underflow <= i_rden & o_empty;
        end
    end
`endif

    fifo_mem u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (i_wrdata),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr_q),
        .rd_data (o_rddata)
    );

endmodule

// File: tb/tb_sync_fifo_128.sv
// Directed bench for sync_fifo_128: fill, drain, full/empty corner
// cases, a queue-model traffic run and a mid-traffic reset.
module tb_sync_fifo_128;

    import fifo_pkg::*;

    logic  clk = 1'b0;
    logic  reset;
    logic  i_wren;
    logic  i_rden;
    word_t i_wrdata;
    logic  o_full;
    logic  o_empty;
    logic  o_alm_full;
    logic  o_alm_empty;
    word_t o_rddata;
`ifdef FIFO_ERR_FLAGS_EN
    logic  o_overflow;
    logic  o_underflow;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sync_fifo_128 dut (
        .clk         (clk),
        .reset       (reset),
        .i_wren      (i_wren),
        .i_rden      (i_rden),
        .i_wrdata    (i_wrdata),
        .o_full      (o_full),
        .o_empty     (o_empty),
        .o_alm_full  (o_alm_full),
        .o_alm_empty (o_alm_empty),
`ifdef FIFO_ERR_FLAGS_EN
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow),
`endif
        .o_rddata    (o_rddata)
    );

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_flags_check(input string tag);
        check({tag, ".empty"}, o_empty, 1);
        check({tag, ".alm_empty"}, o_alm_empty, 1);
        check({tag, ".full"}, o_full, 0);
        check({tag, ".alm_full"}, o_alm_full, 0);
        check({tag, ".rddata"}, o_rddata, 0);
    endtask

    word_t q[$];
    word_t exp_rd;
    logic  wr;
    logic  rd;
    logic  rd_ok;
    logic  wr_ok;

    initial begin
        reset    = 1'b0;
        i_wren   = 1'b0;
        i_rden   = 1'b0;
        i_wrdata = '0;
        step();
        step();
        reset = 1'b1;
        reset_flags_check("rst");

        // Fill 0x1..0x10
        for (int i = 1; i <= 16; i++) begin
            i_wren   = 1'b1;
            i_wrdata = word_t'(i);
            step();
            check($sformatf("fill%0d.alm_empty", i), o_alm_empty, i <= 4);
            check($sformatf("fill%0d.alm_full", i), o_alm_full, i >= 12);
            check($sformatf("fill%0d.full", i), o_full, i == 16);
            check($sformatf("fill%0d.empty", i), o_empty, 0);
        end
        i_wrdata = 128'h99;
        step();
        check("ovf.full", o_full, 1);
`ifdef FIFO_ERR_FLAGS_EN
        check("ovf.pulse", o_overflow, 1);
`endif
        i_wren = 1'b0;
        step();
`ifdef FIFO_ERR_FLAGS_EN
        check("ovf.clear", o_overflow, 0);
`endif

        // Drain
        for (int i = 1; i <= 16; i++) begin
            i_rden = 1'b1;
            step();
            check($sformatf("drain%0d.data", i), o_rddata, 128'(i));
            check($sformatf("drain%0d.empty", i), o_empty, i == 16);
        end
        step();
        check("unf.data", o_rddata, 128'h10);
        check("unf.empty", o_empty, 1);
`ifdef FIFO_ERR_FLAGS_EN
        check("unf.pulse", o_underflow, 1);
`endif
        i_rden = 1'b0;
        step();

        // Simultaneous read+write at full
        for (int i = 1; i <= 16; i++) begin
            i_wren   = 1'b1;
            i_wrdata = word_t'(128'h100 + i);
            step();
        end
        check("rwfull.pre", o_full, 1);
        i_rden   = 1'b1;
        i_wrdata = 128'hAA;
        step();
        check("rwfull.full", o_full, 1);
        check("rwfull.data", o_rddata, 128'h101);
        i_wren = 1'b0;
        for (int i = 2; i <= 16; i++) begin
            step();
            check($sformatf("rwfull.rd%0d", i), o_rddata, 128'h100 + i);
        end
        step();
        check("rwfull.aa", o_rddata, 128'hAA);
        check("rwfull.empty", o_empty, 1);
        i_rden = 1'b0;

        // Simultaneous read+write at empty
        i_wren   = 1'b1;
        i_rden   = 1'b1;
        i_wrdata = 128'h55;
        step();
        check("rwempty.empty", o_empty, 0);
        check("rwempty.data", o_rddata, 128'hAA);
        check("rwempty.count", dut.count_q, 1);
        i_wren = 1'b0;
        step();
        check("rwempty.rd", o_rddata, 128'h55);
        check("rwempty.after", o_empty, 1);
        i_rden = 1'b0;

        // Queue-model traffic with pointer wrap
        exp_rd = 128'h55;
        for (int c = 0; c < 40; c++) begin
            wr = ($urandom_range(0, 99) < 60);
            rd = ($urandom_range(0, 99) < 45);
            i_wren   = wr;
            i_rden   = rd;
            i_wrdata = {$urandom, $urandom, $urandom, $urandom};
            rd_ok = rd && (q.size() > 0);
            wr_ok = wr && ((q.size() < 16) || rd_ok);
            if (rd_ok) exp_rd = q.pop_front();
            if (wr_ok) q.push_back(i_wrdata);
            step();
            check($sformatf("rnd%0d.data", c), o_rddata, exp_rd);
            check($sformatf("rnd%0d.empty", c), o_empty, q.size() == 0);
            check($sformatf("rnd%0d.full", c), o_full, q.size() == 16);
        end

        // Mid-traffic reset
        i_wren = 1'b1;
        i_rden = 1'b1;
        reset  = 1'b0;
        step();
        reset  = 1'b1;
        i_wren = 1'b0;
        i_rden = 1'b0;
        reset_flags_check("midrst");
        check("midrst.count", dut.count_q, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
